drum_access_ctl: RTL and testbench

Drum timing and access sequencer for a bank of recirculating drum_track lines.
- Generates bit-time and word-time counters that define the angular position of every line's output bit.
- Holds every line in recirculation (din = dout).
- Services one queued single-word read or write request at a time by gating the selected line's serial input/output during the target word's 29 bit times.
- Sits between the CPU/sequencer and the drum line array.

---
 rtl/drum_access_ctl.sv | 154 +++++++++++++++
 tb/tb_drum_access_ctl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_access_ctl.sv
// Drum timing generator and single-word access sequencer for recirculating drum lines.
// Counters track the angular position of the bit on trk_dout; one request is serviced at a time.
module drum_access_ctl #(
  parameter int NLINES = 4,
  parameter int WORDS  = 108,
  parameter int BITS   = 29,
  parameter int LW     = $clog2(NLINES),
  parameter int WW     = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NLINES-1:0] trk_dout,
  output logic [NLINES-1:0] trk_din,
  output logic [4:0]        bit_time,
  output logic [WW-1:0]     word_time,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [LW-1:0]     req_line,
  input  logic [WW-1:0]     req_word,
  input  logic [BITS-1:0]   req_wdata,
  output logic              done,
  output logic              err,
  output logic [BITS-1:0]   rdata
);

  localparam logic [4:0]    BIT_LAST  = 5'(BITS - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
  localparam logic [LW:0]   NL        = (LW + 1)'(NLINES);
  localparam logic [WW:0]   NW        = (WW + 1)'(WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        bit_q, bit_d;
  logic [WW-1:0]     word_q, word_d;
  logic [LW-1:0]     line_q, line_d;
  logic [WW-1:0]     addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [BITS-1:0]   wdata_q, wdata_d;
  logic [4:0]        idx_q, idx_d;
  logic [BITS-1:0]   sh_q, sh_d;
  logic [BITS-1:0]   rdata_q, rdata_d;
  logic              errp_q, errp_d;
  logic              done_q, err_q;
  logic              xfer;
  logic [4:0]        xidx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      errp_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      errp_q  <= errp_d;
      done_q  <= (state_d == DONE);
      err_q   <= (state_d == DONE) && errp_d;
    end
  end

  // Position counters free-run regardless of controller state.
  always_comb begin
    bit_d  = bit_q + 5'd1;
    word_d = word_q;
    if (bit_q == BIT_LAST) begin
      bit_d  = '0;
      word_d = (word_q == WORD_LAST) ? '0 : word_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    addr_d    = addr_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    errp_d    = errp_q;
    rdata_d   = rdata_q;
    sh_d      = sh_q;
    xfer      = 1'b0;
    xidx      = idx_q;
    req_ready = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          line_d  = req_line;
          addr_d  = req_word;
          wr_d    = req_write;
          wdata_d = req_wdata;
          if (({1'b0, req_line} < NL) && ({1'b0, req_word} < NW)) begin
            state_d = WAIT;
            errp_d  = 1'b0;
          end else begin
            state_d = DONE;
            errp_d  = 1'b1;
          end
        end
      end
      WAIT: begin
        // Bit 0 of the target word is handled here so XFER only covers bits 1..BITS-1.
        if (bit_q == 5'd0 && word_q == addr_q) begin
          xfer    = 1'b1;
          xidx    = 5'd0;
          idx_d   = 5'd1;
          state_d = XFER;
        end
      end
      XFER: begin
        xfer  = 1'b1;
        idx_d = idx_q + 5'd1;
        if (idx_q == BIT_LAST) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (xfer && !wr_q) sh_d[xidx] = trk_dout[line_q];
    if (state_q == XFER && idx_q == BIT_LAST && !wr_q) rdata_d = sh_d;
  end

  always_comb begin
    trk_din = trk_dout;
    if (xfer && wr_q) trk_din[line_q] = wdata_q[xidx];
  end

  assign bit_time  = bit_q;
  assign word_time = word_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_drum_access_ctl.sv
// Directed bench: two-line, four-word drum with a bench-side track model, plus a
// three-line, five-word instance for out-of-range requests.
module tb_drum_access_ctl;

  localparam int N = 116;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  trk_dout, trk_din;
  logic [4:0]  bit_time;
  logic [1:0]  word_time;
  logic        req_valid, req_ready, req_write;
  logic        req_line;
  logic [1:0]  req_word;
  logic [28:0] req_wdata;
  logic        done, err;
  logic [28:0] rdata;

  logic [2:0]  trk_dout2, trk_din2;
  logic [4:0]  bit_time2;
  logic [2:0]  word_time2;
  logic        req_valid2, req_ready2;
  logic [1:0]  req_line2;
  logic [2:0]  req_word2;
  logic        done2, err2;
  logic [28:0] rdata2;

  logic [N-1:0] trk0, trk1;
  int           ptr = 0;
  int           origin0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  drum_access_ctl #(.NLINES(2), .WORDS(4), .BITS(29)) dut (
    .clk(clk), .rst(rst), .trk_dout(trk_dout), .trk_din(trk_din),
    .bit_time(bit_time), .word_time(word_time),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_line(req_line), .req_word(req_word), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata)
  );

  drum_access_ctl #(.NLINES(3), .WORDS(5), .BITS(29)) dut2 (
    .clk(clk), .rst(rst), .trk_dout(trk_dout2), .trk_din(trk_din2),
    .bit_time(bit_time2), .word_time(word_time2),
    .req_valid(req_valid2), .req_ready(req_ready2), .req_write(1'b1),
    .req_line(req_line2), .req_word(req_word2), .req_wdata(29'h1FFFFFFF),
    .done(done2), .err(err2), .rdata(rdata2)
  );

  // Circular drum tracks: dout is the bit under the head, din is written as it passes.
  assign trk_dout = {trk1[ptr], trk0[ptr]};
  always @(posedge clk) begin
    trk0[ptr] <= trk_din[0];
    trk1[ptr] <= trk_din[1];
    ptr       <= (ptr == N - 1) ? 0 : ptr + 1;
  end

  always @(posedge clk) trk_dout2 <= trk_dout2 + 3'd3;

  task automatic wait_pos(input int w, input int b);
    int t = 0;
    while (!(int'(word_time) == w && int'(bit_time) == b) && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_pos: position w%0d b%0d never reached", w, b);
    end
  endtask

  task automatic issue(input logic wr, input logic line, input logic [1:0] word,
                       input logic [28:0] data);
    req_valid = 1'b1; req_write = wr; req_line = line; req_word = word; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: no done pulse within 400 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_line = 1'b0; req_word = '0; req_wdata = '0;
    req_valid2 = 1'b0; req_line2 = '0; req_word2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    origin0 = ptr;
    n_cmp++; if ({word_time, bit_time} !== 7'd0) begin n_bad++;
      $display("FAIL reset_pos: got w%0d b%0d want w0 b0", word_time, bit_time); end
    n_cmp++; if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_bad++;
      $display("FAIL reset_ctl: ready=%b done=%b err=%b want 1 0 0", req_ready, done, err); end
    n_cmp++; if (rdata !== 29'd0) begin n_bad++;
      $display("FAIL reset_rdata: got %h want 0", rdata); end
    for (int i = 1; i < 29; i++) begin
      @(negedge clk);
      n_cmp++; if (int'(bit_time) != i || word_time !== 2'd0) begin n_bad++;
        $display("FAIL bit_count: got w%0d b%0d want w0 b%0d", word_time, bit_time, i); end
    end
    @(negedge clk);
    n_cmp++; if (word_time !== 2'd1 || bit_time !== 5'd0) begin n_bad++;
      $display("FAIL word_inc: got w%0d b%0d want w1 b0", word_time, bit_time); end
    wait_pos(3, 28);
    @(negedge clk);
    n_cmp++; if (word_time !== 2'd0 || bit_time !== 5'd0) begin n_bad++;
      $display("FAIL word_wrap: got w%0d b%0d want w0 b0", word_time, bit_time); end
  endtask

  task automatic test_write();
    logic [28:0] d = 29'h0ABCDEF1;
    logic        exp1;
    int          n = 1;
    wait_pos(0, 5);
    issue(1'b1, 1'b1, 2'd2, d);
    while (!done && n < 400) begin
      n_cmp++; if (trk_din[0] !== trk_dout[0]) begin n_bad++;
        $display("FAIL write_line0_recirc: din=%b dout=%b", trk_din[0], trk_dout[0]); end
      exp1 = (word_time == 2'd2) ? d[bit_time] : trk_dout[1];
      n_cmp++; if (trk_din[1] !== exp1) begin n_bad++;
        $display("FAIL write_line1_din: w%0d b%0d got %b want %b", word_time, bit_time,
                 trk_din[1], exp1); end
      @(negedge clk);
      n++;
    end
    n_cmp++; if (done !== 1'b1 || err !== 1'b0 || n != 82) begin n_bad++;
      $display("FAIL write_done: done=%b err=%b after %0d cycles want 1 0 82", done, err, n); end
    n_cmp++; if (word_time !== 2'd3 || bit_time !== 5'd0) begin n_bad++;
      $display("FAIL write_done_pos: got w%0d b%0d want w3 b0", word_time, bit_time); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || req_ready !== 1'b1) begin n_bad++;
      $display("FAIL write_done_pulse: done=%b ready=%b want 0 1", done, req_ready); end
  endtask

  task automatic test_readback();
    int n;
    issue(1'b0, 1'b1, 2'd2, 29'h0);
    wait_done(n);
    n_cmp++; if (rdata !== 29'h0ABCDEF1 || err !== 1'b0) begin n_bad++;
      $display("FAIL read_l1w2: rdata=%h err=%b want 0abcdef1 0", rdata, err); end
    @(negedge clk);
    issue(1'b0, 1'b0, 2'd2, 29'h0);
    wait_done(n);
    n_cmp++; if (rdata !== 29'h0) begin n_bad++;
      $display("FAIL read_l0w2: rdata=%h want 0", rdata); end
  endtask

  task automatic test_align();
    int n;
    wait_pos(1, 28);
    issue(1'b0, 1'b1, 2'd2, 29'h0);
    wait_done(n);
    n_cmp++; if (n != 30 || word_time !== 2'd3 || bit_time !== 5'd0) begin n_bad++;
      $display("FAIL align_hit: %0d cycles at w%0d b%0d want 30 at w3 b0", n, word_time, bit_time); end
    n_cmp++; if (rdata !== 29'h0ABCDEF1) begin n_bad++;
      $display("FAIL align_hit_rdata: got %h want 0abcdef1", rdata); end
    wait_pos(2, 0);
    issue(1'b0, 1'b1, 2'd2, 29'h0);
    wait_done(n);
    n_cmp++; if (n != 145 || word_time !== 2'd3 || bit_time !== 5'd0) begin n_bad++;
      $display("FAIL align_miss: %0d cycles at w%0d b%0d want 145 at w3 b0", n, word_time, bit_time); end
  endtask

  task automatic test_reset_mid_write();
    int n;
    int t = 0;
    wait_pos(0, 0);
    issue(1'b1, 1'b1, 2'd2, 29'h1FFFFFFF);
    wait_pos(2, 10);
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || done !== 1'b0 || {word_time, bit_time} !== 7'd0) begin
      n_bad++;
      $display("FAIL midrst_state: ready=%b done=%b w%0d b%0d want 1 0 w0 b0",
               req_ready, done, word_time, bit_time); end
    n_cmp++; if (trk_din[1] !== trk_dout[1]) begin n_bad++;
      $display("FAIL midrst_din: din=%b dout=%b", trk_din[1], trk_dout[1]); end
    // Hold reset until the head returns to the original origin so word 2 lines up again.
    while (ptr != origin0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    rst = 1'b0;
    n_cmp++; if (done !== 1'b0 || req_ready !== 1'b1 || t >= 200) begin n_bad++;
      $display("FAIL midrst_release: done=%b ready=%b t=%0d", done, req_ready, t); end
    issue(1'b0, 1'b1, 2'd2, 29'h0);
    wait_done(n);
    n_cmp++; if (rdata !== 29'h0ABCDFFF) begin n_bad++;
      $display("FAIL midrst_read: got %h want 0abcdfff", rdata); end
  endtask

  task automatic test_range_err();
    @(negedge clk);
    req_valid2 = 1'b1; req_line2 = 2'd3; req_word2 = 3'd0;
    @(negedge clk);
    req_valid2 = 1'b0;
    n_cmp++; if (done2 !== 1'b1 || err2 !== 1'b1) begin n_bad++;
      $display("FAIL err_line: done=%b err=%b want 1 1", done2, err2); end
    n_cmp++; if (trk_din2 !== trk_dout2) begin n_bad++;
      $display("FAIL err_line_din: din=%b dout=%b", trk_din2, trk_dout2); end
    @(negedge clk);
    n_cmp++; if (done2 !== 1'b0 || err2 !== 1'b0 || req_ready2 !== 1'b1) begin n_bad++;
      $display("FAIL err_pulse: done=%b err=%b ready=%b want 0 0 1", done2, err2, req_ready2); end
    req_valid2 = 1'b1; req_line2 = 2'd0; req_word2 = 3'd5;
    @(negedge clk);
    req_valid2 = 1'b0;
    n_cmp++; if (done2 !== 1'b1 || err2 !== 1'b1 || rdata2 !== 29'd0) begin n_bad++;
      $display("FAIL err_word: done=%b err=%b rdata=%h want 1 1 0", done2, err2, rdata2); end
    n_cmp++; if (trk_din2 !== trk_dout2) begin n_bad++;
      $display("FAIL err_word_din: din=%b dout=%b", trk_din2, trk_dout2); end
    @(negedge clk);
    req_valid2 = 1'b1; req_line2 = 2'd2; req_word2 = 3'd4;
    @(negedge clk);
    req_valid2 = 1'b0;
    n_cmp++; if (done2 !== 1'b0 || req_ready2 !== 1'b0) begin n_bad++;
      $display("FAIL inrange_accept: done=%b ready=%b want 0 0", done2, req_ready2); end
  endtask

  initial begin
    trk0 = '0;
    trk1 = '0;
    trk_dout2 = 3'd0;
    test_reset();
    test_write();
    test_readback();
    test_align();
    test_reset_mid_write();
    test_range_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
